// File: rtl/ram_rcmd_gen.sv
// AXI read-address front end: expands one accepted AR burst into one RAM read
// command per beat, {last, id, word_addr}, pushed under FIFO-full backpressure.
module ram_rcmd_gen #(
   parameter int C_ID        = 16,
   parameter int C_RAM_AW    = 15,
   parameter int C_AXI_AW    = 32,
   parameter int C_SIZE_LOG2 = 3
) (
   input  logic                         aclk_s,
   input  logic                         rst_n,
   input  logic                         s_arvalid,
   output logic                         s_arready,
   input  logic [C_ID-1:0]              s_arid,
   input  logic [C_AXI_AW-1:0]          s_araddr,
   input  logic [7:0]                   s_arlen,
   input  logic [2:0]                   s_arsize,
   input  logic [1:0]                   s_arburst,
   input  logic                         ram_cmd_full,
   output logic                         ram_cmd_push,
   output logic [C_ID+C_RAM_AW+1:0]     ram_cmd_info,
   output logic                         busy
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_reg, state_next;
   logic [C_AXI_AW-1:0]   cur_addr_reg, cur_addr_next;
   logic [7:0]            beat_cnt_reg, beat_cnt_next;
   logic [C_ID-1:0]       id_reg, id_next;
   logic [2:0]            size_reg, size_next;
   logic [1:0]            burst_reg, burst_next;
   logic [C_AXI_AW-1:0]   wrap_mask_reg, wrap_mask_next;

   logic [2:0]            eff_size;
   logic [C_AXI_AW-1:0]   len_ext;
   logic [C_AXI_AW-1:0]   incr;
   logic [C_AXI_AW-1:0]   adv_addr;

   // Transfers wider than the bus are clamped to the bus width.
   assign eff_size = (s_arsize > 3'(C_SIZE_LOG2)) ? 3'(C_SIZE_LOG2) : s_arsize;
   assign len_ext  = C_AXI_AW'(s_arlen) + C_AXI_AW'(1);
   assign incr     = C_AXI_AW'(1) << size_reg;

   always_comb begin
      adv_addr = cur_addr_reg;
      case (burst_reg)
         2'b00:   adv_addr = cur_addr_reg;
         2'b10:   adv_addr = (cur_addr_reg & ~wrap_mask_reg) |
                             ((cur_addr_reg + incr) & wrap_mask_reg);
         default: adv_addr = (cur_addr_reg & ~(incr - C_AXI_AW'(1))) + incr;
      endcase
   end

   assign ram_cmd_info = {(beat_cnt_reg == 8'd0), id_reg,
                          cur_addr_reg[C_SIZE_LOG2 +: C_RAM_AW+1]};

   always_comb begin
      state_next     = state_reg;
      cur_addr_next  = cur_addr_reg;
      beat_cnt_next  = beat_cnt_reg;
      id_next        = id_reg;
      size_next      = size_reg;
      burst_next     = burst_reg;
      wrap_mask_next = wrap_mask_reg;
      s_arready      = 1'b0;
      ram_cmd_push   = 1'b0;
      busy           = 1'b0;
      case (state_reg)
         IDLE: begin
            s_arready = 1'b1;
            if (s_arvalid) begin
               id_next        = s_arid;
               cur_addr_next  = s_araddr;
               beat_cnt_next  = s_arlen;
               size_next      = eff_size;
               burst_next     = s_arburst;
               wrap_mask_next = (len_ext << eff_size) - C_AXI_AW'(1);
               state_next     = BURST;
            end
         end
         BURST: begin
            busy         = 1'b1;
            ram_cmd_push = ~ram_cmd_full;
            if (!ram_cmd_full) begin
               cur_addr_next = adv_addr;
               beat_cnt_next = beat_cnt_reg - 8'd1;
               if (beat_cnt_reg == 8'd0) begin
                  beat_cnt_next = 8'd0;
                  state_next    = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk_s or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cur_addr_reg  <= '0;
         beat_cnt_reg  <= '0;
         id_reg        <= '0;
         size_reg      <= '0;
         burst_reg     <= '0;
         wrap_mask_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cur_addr_reg  <= cur_addr_next;
         beat_cnt_reg  <= beat_cnt_next;
         id_reg        <= id_next;
         size_reg      <= size_next;
         burst_reg     <= burst_next;
         wrap_mask_reg <= wrap_mask_next;
      end
   end

endmodule

// File: doc/ram_rcmd_gen.md
Name: ram_rcmd_gen

Overview:
- AXI read-address front end for the AXI RAM slave; sits directly upstream of the read-command FIFO.
- Accepts one AR burst at a time and expands it into one RAM read command per beat.
- Each command is {last, id, ram word address}, pushed under FIFO-full backpressure.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and unaligned INCR starts.

Parameters:
- C_ID, 16, AXI ID width.
- C_RAM_AW, 15, RAM word-address width minus 1; the command address field is C_RAM_AW+1 bits.
- C_AXI_AW, 32, AXI byte-address width.
- C_SIZE_LOG2, 3, log2 of data-bus bytes (3 = 64-bit bus).

Ports:
- aclk_s  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- s_arid  in  C_ID  AR ID.
- s_araddr  in  C_AXI_AW  AR byte address.
- s_arlen  in  8  beats minus 1.
- s_arsize  in  3  log2 bytes per beat.
- s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ram_cmd_full  in  1  read-command FIFO full.
- ram_cmd_push  out  1  push one command.
- ram_cmd_info  out  C_ID+C_RAM_AW+2  {last, id, word_addr[C_RAM_AW:0]}.
- busy  out  1  burst in progress.

Behaviour:
- Reset state: IDLE.
- Outputs in reset: s_arready=1, ram_cmd_push=0, busy=0.
- Internal registers reset to 0: cur_addr, beat_cnt, id, size, burst, wrap_mask.
- FSM IDLE:
  - s_arready=1.
  - On s_arvalid, latch id, araddr, arlen, eff_size and burst, then go to BURST.
  - eff_size = min(arsize, C_SIZE_LOG2).
  - beat_cnt = arlen.
- FSM BURST:
  - s_arready=0 and busy=1.
  - ram_cmd_push = ~ram_cmd_full. This is combinational from state and full; there is no registered delay.
  - On each push, advance cur_addr and decrement beat_cnt.
  - The push with beat_cnt==0 carries last=1; the next state is IDLE.
  - There is a 1-cycle AR bubble between bursts. Back-to-back acceptance is not required.
- ram_cmd_info:
  - Driven combinationally from registers.
  - word_addr = cur_addr[C_SIZE_LOG2 +: C_RAM_AW+1]. Upper address bits are ignored (RAM aliases).
  - last = (beat_cnt==0).
  - The field is stable while ram_cmd_full is high.
- Address advance, with incr = 1<<eff_size:
  - FIXED: cur_addr unchanged.
  - INCR or reserved 11: next = (cur_addr & ~(incr-1)) + incr. An unaligned first beat therefore aligns on the second beat.
  - WRAP: wrap_mask = ((arlen+1)<<eff_size)-1, computed at AR accept. Next = (cur_addr & ~wrap_mask) | ((cur_addr+incr) & wrap_mask).
  - WRAP arlen must be 1/3/7/15; other values are not checked and behave per the formula.
- Arithmetic is C_AXI_AW bits wide and wraps modulo 2^C_AXI_AW.
- No 4KB-crossing check; the master guarantees legality.
- Backpressure: while ram_cmd_full=1, no push and no state or address change. Full may toggle every cycle.
- A single-beat burst (arlen=0) gives one push with last=1 and returns to IDLE.
- s_arvalid during BURST is ignored (s_arready=0). The AR payload is sampled only at the handshake.
- Reset asserted mid-burst:
  - Immediate return to IDLE; push drops to 0 asynchronously and the partial burst is discarded.
  - The downstream FIFO is reset by the same rst_n.

Test Plan:
- INCR, size 3, arlen 3, addr 0x100, id 0x5, full=0 -> pushes on 4 consecutive cycles. word_addr 0x20, 0x21, 0x22, 0x23; last only on 0x23; id 0x5 on all.
- WRAP, size 3, arlen 3, addr 0x118 -> word_addr 0x23, 0x20, 0x21, 0x22, last on 0x22.
- FIXED, arlen 2, addr 0x40 -> three pushes of word_addr 0x08, last on the third.
- Narrow INCR, size 2, arlen 3, addr 0x106 -> bytes 0x106, 0x108, 0x10C, 0x110. word_addr 0x20, 0x21, 0x21, 0x22.
- Backpressure: INCR arlen 3, ram_cmd_full high for 3 cycles after the first push -> ram_cmd_info holds 0x21 with push=0, then resumes. Total 4 pushes, none duplicated or lost; s_arready low until the cycle after the last push.
- Reset: assert rst_n=0 after 2 beats of an arlen 7 burst -> push=0 and s_arready=1 immediately. The next burst (arlen 0, addr 0x0) produces a single push, word_addr 0, last=1.
